// File: rtl/td4_loader_pkg.sv
// Shared types and constants for the TD4 UART program loader.
// Used by uart_prog_loader.
package td4_loader_pkg;

    localparam int         PROG_DEPTH        = 16;
    localparam logic [7:0] INIT_INSTR        = 8'hF0;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ERR,
        DONE
    } loader_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser.
// Emits one-clk byte_valid or frame_err pulses at the stop-bit centre.
module uart_rx #(
    parameter int BIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int            CW        = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);

    logic          r_sync1, r_sync2, r_prev;
    rx_state_t     r_state, w_nextState;
    logic [CW-1:0] r_cnt, w_nextCnt;
    logic [2:0]    r_bitIdx, w_nextBitIdx;
    logic [7:0]    r_shift, w_nextShift;
    logic          r_valid, w_nextValid;
    logic          r_ferr, w_nextFerr;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_prev   <= 1'b1;
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_bitIdx <= w_nextBitIdx;
            r_shift  <= w_nextShift;
            r_valid  <= w_nextValid;
            r_ferr   <= w_nextFerr;
        end
    end

    // The half-bit recheck realigns the counter so later samples land at bit centres.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt + 1'b1;
        w_nextBitIdx = r_bitIdx;
        w_nextShift  = r_shift;
        w_nextValid  = 1'b0;
        w_nextFerr   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_nextCnt = '0;
                if (r_prev && !r_sync2) w_nextState = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_nextCnt    = '0;
                    w_nextBitIdx = '0;
                    w_nextState  = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_nextCnt    = '0;
                    w_nextShift  = {r_sync2, r_shift[7:1]};
                    w_nextBitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) w_nextState = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_nextCnt   = '0;
                    w_nextState = RX_IDLE;
                    w_nextValid = r_sync2;
                    w_nextFerr  = !r_sync2;
                end
            end
            default: w_nextState = RX_IDLE;
        endcase
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// Writable 16x8 TD4 program store loaded over UART; holds the CPU in reset while loading.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the 16 data bytes.
module uart_prog_loader
    import td4_loader_pkg::*;
#(
    parameter int         CLK_HZ       = 25_000_000,
    parameter int         BAUD         = 115_200,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    input  logic [3:0] addr,
    output logic [7:0] instr,
    output logic       cpu_n_reset,
    output logic       loading,
    output logic       load_done,
    output logic       load_err
);

    localparam int            BIT_CYCLES   = CLK_HZ / BAUD;
    localparam int            TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CYCLES;
    localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    logic          w_byteValid, w_frameErr;
    logic [7:0]    w_byteData;
    loader_state_t r_state, w_nextState;
    logic [3:0]    r_idx;
    logic [TW-1:0] r_timer;
    logic          w_write, w_timeout, w_enterLoad;
    logic          r_loading, r_loadDone, r_loadErr, r_cpuRun;
    // Power-up content is a JMP 0 loop; reset deliberately leaves the array alone.
    logic [7:0]    r_mem [PROG_DEPTH] = '{default: INIT_INSTR};
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_sum;
`endif

    uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx),
        .byte_valid (w_byteValid),
        .byte_data  (w_byteData),
        .frame_err  (w_frameErr)
    );

    assign w_timeout   = (r_timer == TIMEOUT_LAST);
    assign w_enterLoad = (w_nextState == LOAD) && (r_state != LOAD);

    always_comb begin
        w_nextState = r_state;
        w_write     = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_byteValid && w_byteData == SYNC_BYTE) w_nextState = LOAD;
            end
            LOAD: begin
                if (w_byteValid) begin
                    w_write = 1'b1;
                    if (r_idx == 4'(PROG_DEPTH - 1)) begin
`ifdef LOADER_CHECKSUM_EN
                        w_nextState = CHECK;
`else
                        w_nextState = DONE;
`endif
                    end
                end else if (w_frameErr || w_timeout) begin
                    w_nextState = ERR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (w_byteValid) w_nextState = (w_byteData == r_sum) ? DONE : ERR;
                else if (w_frameErr || w_timeout) w_nextState = ERR;
            end
`endif
            default: w_nextState = IDLE;
        endcase
    end

    // Flags are decoded from the next state so they change together with it.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_loading  <= 1'b0;
            r_loadDone <= 1'b0;
            r_loadErr  <= 1'b0;
            r_cpuRun   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_loading  <= (w_nextState == LOAD) || (w_nextState == CHECK);
            r_loadDone <= (w_nextState == DONE);
            r_loadErr  <= (w_nextState == ERR);
            r_cpuRun   <= (w_nextState == IDLE) || (w_nextState == DONE);
            if (w_enterLoad) r_idx <= '0;
            else if (w_write) r_idx <= r_idx + 4'd1;
            if (((r_state == LOAD) || (r_state == CHECK)) && !w_byteValid)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!n_reset) r_sum <= '0;
        else if (w_enterLoad) r_sum <= '0;
        else if (w_write) r_sum <= r_sum + w_byteData;
    end
`endif

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_idx] <= w_byteData;
    end

    assign instr       = r_mem[addr];
    assign cpu_n_reset = r_cpuRun;
    assign loading     = r_loading;
    assign load_done   = r_loadDone;
    assign load_err    = r_loadErr;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed scenarios with random payloads
// compared against a byte-level behavioural model of the loader.
module tb_uart_prog_loader;

    localparam int BITC = 10;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] addr = 4'd0;
    logic [7:0] instr;
    logic       cpu_n_reset, loading, load_done, load_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] expMem [16];
    logic [7:0] progBuf [16];
    bit         mLoad, mCheck, mDone, mErr;
    int         mIdx;
    logic [7:0] mSum;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_HZ       (1_000_000),
        .BAUD         (100_000),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx          (rx),
        .addr        (addr),
        .instr       (instr),
        .cpu_n_reset (cpu_n_reset),
        .loading     (loading),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: reacts to whole received bytes, not to clocks.
    task automatic modelByte(input logic [7:0] b, input bit ok);
        if (mLoad) begin
            if (!ok) begin
                mLoad = 0;
                mErr  = 1;
            end else begin
                expMem[mIdx] = b;
                mSum = mSum + b;
                mIdx++;
                if (mIdx == 16) begin
                    mLoad = 0;
`ifdef LOADER_CHECKSUM_EN
                    mCheck = 1;
`else
                    mDone = 1;
`endif
                end
            end
        end else if (mCheck) begin
            mCheck = 0;
            if (ok && b == mSum) mDone = 1;
            else mErr = 1;
        end else if (ok && b == 8'hA5) begin
            mLoad = 1;
            mDone = 0;
            mErr  = 0;
            mIdx  = 0;
            mSum  = 8'h00;
        end
    endtask

    task automatic modelTimeout();
        if (mLoad || mCheck) begin
            mLoad  = 0;
            mCheck = 0;
            mErr   = 1;
        end
    endtask

    task automatic modelReset();
        mLoad  = 0;
        mCheck = 0;
        mDone  = 0;
        mErr   = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopBit);
        @(negedge clk);
        rx = 1'b0;
        idle(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BITC);
        end
        rx = stopBit;
        idle(BITC);
        rx = 1'b1;
        modelByte(b, stopBit);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ":loading"}, 8'(loading), 8'(mLoad || mCheck));
        check({tag, ":load_done"}, 8'(load_done), 8'(mDone));
        check({tag, ":load_err"}, 8'(load_err), 8'(mErr));
        check({tag, ":cpu_n_reset"}, 8'(cpu_n_reset), 8'(!(mLoad || mCheck || mErr)));
    endtask

    task automatic checkMem(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check($sformatf("%s:instr[%0d]", tag, a), instr, expMem[a]);
        end
    endtask

    task automatic randomProg();
        for (int i = 0; i < 16; i++) progBuf[i] = 8'($urandom);
    endtask

    task automatic loadData();
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(progBuf[i], 1'b1);
    endtask

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] progSum();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + progBuf[i];
        return s;
    endfunction
`endif

    task automatic loadProgram();
        loadData();
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(progSum(), 1'b1);
`endif
    endtask

    // Directed scenarios run in order; random payloads vary each run.
    initial begin
        logic [7:0] noise;
        for (int i = 0; i < 16; i++) expMem[i] = 8'hF0;
        modelReset();

        // Reset and power-up
        idle(3);
        check("rst:cpu_n_reset", 8'(cpu_n_reset), 8'h00);
        check("rst:loading", 8'(loading), 8'h00);
        check("rst:load_done", 8'(load_done), 8'h00);
        check("rst:load_err", 8'(load_err), 8'h00);
        n_reset = 1'b1;
        #1;
        check("rel:cpu_n_reset_still_low", 8'(cpu_n_reset), 8'h00);
        idle(1);
        checkOutput("rel");
        checkMem("powerup");

        // Non-sync bytes and a short glitch in IDLE
        applyStimulus(8'h3C, 1'b1);
        checkOutput("idle_3C");
        noise = 8'($urandom);
        if (noise == 8'hA5) noise = 8'h5A;
        applyStimulus(noise, 1'b1);
        checkOutput("idle_rand");
        @(negedge clk);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3 * BITC);
        checkOutput("glitch");

        // Good load with the reference program
        progBuf = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                    8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        applyStimulus(8'hA5, 1'b1);
        checkOutput("after_sync");
        for (int i = 0; i < 15; i++) applyStimulus(progBuf[i], 1'b1);
        checkOutput("before_last");
        applyStimulus(progBuf[15], 1'b1);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(progSum(), 1'b1);
`endif
        checkOutput("good_load");
        addr = 4'd0;  #1; check("prog:addr0", instr, 8'hB7);
        addr = 4'd14; #1; check("prog:addr14", instr, 8'hB8);
        addr = 4'd15; #1; check("prog:addr15", instr, 8'hFF);

        // Non-sync byte in DONE is ignored
        applyStimulus(8'h3C, 1'b1);
        checkOutput("done_ignore");

        // Timeout after a partial load, then recovery
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1'b1);
        idle(300);
        checkOutput("pre_timeout");
        idle(120);
        modelTimeout();
        checkOutput("timeout");
        randomProg();
        loadProgram();
        checkOutput("recover");
        checkMem("recover");

        // Framing error on the third data byte
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'($urandom), 1'b1);
        applyStimulus(8'($urandom), 1'b1);
        applyStimulus(8'($urandom), 1'b0);
        checkOutput("frame_err");
        checkMem("frame_err");
        idle(2 * BITC);

        // Reset in the middle of a load
        randomProg();
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(progBuf[i], 1'b1);
        checkOutput("mid_load");
        n_reset = 1'b0;
        idle(3);
        check("midrst:cpu_n_reset", 8'(cpu_n_reset), 8'h00);
        check("midrst:loading", 8'(loading), 8'h00);
        check("midrst:load_err", 8'(load_err), 8'h00);
        n_reset = 1'b1;
        modelReset();
        idle(1);
        checkOutput("midrst_rel");
        checkMem("midrst");

`ifdef LOADER_CHECKSUM_EN
        // Wrong and correct checksum
        loadData();
        applyStimulus(progSum() - 8'h01, 1'b1);
        checkOutput("sum_bad");
        loadData();
        applyStimulus(progSum(), 1'b1);
        checkOutput("sum_good");
        checkMem("sum_good");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
